zx_beeper_covox_dac: RTL and testbench

- Downstream consumer of the bus-decoder CPLD's sound-side outputs: the `covox` write strobe, `beeper` and `tapeout` levels, and the data bus.
- Latches covox samples into the `cpu_clock` domain, mixes them with beeper and tape levels, and drives a first-order sigma-delta 1-bit DAC.
- The `pwm_out` pin feeds the external RC filter, which is summed with the YM outputs.

---
 rtl/zx_beeper_covox_dac_pkg.sv | 22 ++
 rtl/zx_beeper_covox_dac_sd_dac1.sv | 30 +++
 rtl/zx_beeper_covox_dac.sv | 95 +++++++++
 tb/tb_zx_beeper_covox_dac.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/zx_beeper_covox_dac_pkg.sv
// Shared constants for the covox/beeper sigma-delta DAC: default levels,
// capture FSM encoding and width helpers.
package zx_beeper_covox_dac_pkg;

  localparam int MIX_W_DEF      = 10;
  localparam int BEEP_LEVEL_DEF = 192;
  localparam int TAPE_LEVEL_DEF = 48;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HELD = 1'b1;

  // One extra bit holds the unsaturated sum before clamping to MIX_W bits.
  function automatic int sat_add_w(input int mix_w);
    return mix_w + 1;
  endfunction

  // Idle counter must represent the timeout without wrapping; min 1 bit.
  function automatic int cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/zx_beeper_covox_dac_sd_dac1.sv
// First-order sigma-delta 1-bit DAC: accumulator whose top bit is the
// registered carry driving the output pin.
module sd_dac1 #(
  parameter int MIX_W = 10
) (
  input  logic             cpu_clock,
  input  logic             reset,
  input  logic             hold,
  input  logic [MIX_W-1:0] mix,
  output logic             bit_out
);

  logic [MIX_W:0] acc_q, acc_d;
  logic [MIX_W:0] sum;

  // The low bits carry the phase and freeze on hold; the top bit is the
  // output carry and is cleared so the pin goes quiet.
  always_comb begin
    sum   = {1'b0, acc_q[MIX_W-1:0]} + {1'b0, mix};
    acc_d = hold ? {1'b0, acc_q[MIX_W-1:0]} : sum;
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign bit_out = acc_q[MIX_W];

endmodule

// File: rtl/zx_beeper_covox_dac.sv
// Covox sample capture from the decoder strobe, beeper/tape mixing with
// saturation, and a sigma-delta bitstream for the external RC filter.
module zx_beeper_covox_dac
  import zx_beeper_covox_dac_pkg::*;
#(
  parameter int MIX_W        = MIX_W_DEF,
  parameter int BEEP_LEVEL   = BEEP_LEVEL_DEF,
  parameter int TAPE_LEVEL   = TAPE_LEVEL_DEF,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       covox,
  input  logic [7:0] d,
  input  logic       beeper,
  input  logic       tapeout,
  input  logic       snd_mute,
  output logic       pwm_out,
  output logic [7:0] sample_q
);

  localparam int SW = sat_add_w(MIX_W);
  localparam int CW = cnt_w(IDLE_TIMEOUT);
  localparam logic          TO_EN   = (IDLE_TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'((IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1);

  logic [1:0]    sync_s_q, sync_s_d;
  logic [7:0]    d_s1_q, d_s2_q;
  logic          state_q, state_d;
  logic [7:0]    sample_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [SW-1:0] mix_raw;
  logic [MIX_W-1:0] mix;

  always_comb begin
    sync_s_d   = {sync_s_q[0], covox};
    state_d    = state_q;
    sample_d   = sample_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Capture beats the timeout when both land on the same cycle.
        if (sync_s_q[1]) begin
          state_d    = ST_HELD;
          sample_d   = d_s2_q;
          idle_cnt_d = '0;
        end else if (TO_EN && sample_q != 8'h00) begin
          if (idle_cnt_q == TO_LAST) begin
            sample_d   = 8'h00;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
      end
      default: if (!sync_s_q[1]) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      sync_s_q   <= '0;
      d_s1_q     <= '0;
      d_s2_q     <= '0;
      state_q    <= ST_IDLE;
      sample_q   <= '0;
      idle_cnt_q <= '0;
    end else begin
      sync_s_q   <= sync_s_d;
      d_s1_q     <= d;
      d_s2_q     <= d_s1_q;
      state_q    <= state_d;
      sample_q   <= sample_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Beeper and tape are decoder-latched levels; used without resync.
  always_comb begin
    mix_raw = SW'(sample_q) + (beeper ? SW'(BEEP_LEVEL) : SW'(0))
            + (tapeout ? SW'(TAPE_LEVEL) : SW'(0));
    if (snd_mute)          mix = '0;
    else if (mix_raw[SW-1]) mix = '1;
    else                   mix = mix_raw[MIX_W-1:0];
  end

  sd_dac1 #(.MIX_W(MIX_W)) u_dac (
    .cpu_clock (cpu_clock),
    .reset     (reset),
    .hold      (snd_mute),
    .mix       (mix),
    .bit_out   (pwm_out)
  );

endmodule

// File: tb/tb_zx_beeper_covox_dac.sv
// Directed bench: capture timing, density counts, saturation, idle timeout,
// reset mid-strobe and mute hold, over three parameterisations.
module tb_zx_beeper_covox_dac;

  logic       cpu_clock = 1'b0;
  logic       reset, covox, beeper, tapeout, snd_mute;
  logic [7:0] d;
  logic       pwm_a, pwm_to, pwm_sat;
  logic [7:0] smp_a, smp_to, smp_sat;

  int checks = 0;
  int errors = 0;
  int ones_a, ones_to, ones_sat;

  always #5 cpu_clock = ~cpu_clock;

  zx_beeper_covox_dac dut (
    .cpu_clock(cpu_clock), .reset(reset), .covox(covox), .d(d), .beeper(beeper),
    .tapeout(tapeout), .snd_mute(snd_mute), .pwm_out(pwm_a), .sample_q(smp_a));

  zx_beeper_covox_dac #(.IDLE_TIMEOUT(100)) dut_to (
    .cpu_clock(cpu_clock), .reset(reset), .covox(covox), .d(d), .beeper(beeper),
    .tapeout(tapeout), .snd_mute(snd_mute), .pwm_out(pwm_to), .sample_q(smp_to));

  zx_beeper_covox_dac #(.BEEP_LEVEL(1000)) dut_sat (
    .cpu_clock(cpu_clock), .reset(reset), .covox(covox), .d(d), .beeper(beeper),
    .tapeout(tapeout), .snd_mute(snd_mute), .pwm_out(pwm_sat), .sample_q(smp_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge cpu_clock);
  endtask

  task automatic count(input int n);
    ones_a = 0; ones_to = 0; ones_sat = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge cpu_clock);
      ones_a   += int'(pwm_a);
      ones_to  += int'(pwm_to);
      ones_sat += int'(pwm_sat);
    end
  endtask

  initial begin
    int pre;
    reset = 1'b0; covox = 1'b0; d = 8'h00;
    beeper = 1'b0; tapeout = 1'b0; snd_mute = 1'b0;
    tick(2);
    chk("rst_smp_a", 32'(smp_a), 0);
    chk("rst_pwm_a", 32'(pwm_a), 0);
    chk("rst_smp_to", 32'(smp_to), 0);
    chk("rst_pwm_to", 32'(pwm_to), 0);
    chk("rst_smp_sat", 32'(smp_sat), 0);
    chk("rst_pwm_sat", 32'(pwm_sat), 0);
    reset = 1'b1;

    // Mute mid-tone: 300 + 724 live additions of 192 from acc=0 give 192.
    beeper = 1'b1;
    count(300);
    pre = ones_a;
    chk("pre_mute_ones", 32'(pre), 56);
    snd_mute = 1'b1;
    count(50);
    chk("muted_ones", 32'(ones_a), 0);
    snd_mute = 1'b0;
    count(724);
    chk("mute_resume_ones", 32'(pre + ones_a), 192);
    beeper = 1'b0;
    tick(2);

    // Covox write 0x40, strobe held 3 clocks.
    covox = 1'b1; d = 8'h40;
    tick(2);
    chk("cap_not_yet", 32'(smp_a), 0);
    tick(1);
    chk("cap_lat3", 32'(smp_a), 32'h40);
    covox = 1'b0; d = 8'h99;
    tick(4);
    chk("cap_once", 32'(smp_a), 32'h40);
    count(1024);
    chk("dens_40", 32'(ones_a), 64);

    // Long strobe: data changes while held, only the first value lands.
    covox = 1'b1; d = 8'h00;
    tick(3);
    d = 8'h55;
    tick(6);
    chk("long_strobe_once", 32'(smp_a), 0);
    covox = 1'b0;
    tick(3);

    beeper = 1'b1;
    count(1024);
    chk("dens_beep", 32'(ones_a), 192);
    chk("dens_beep_big", 32'(ones_sat), 1000);
    tapeout = 1'b1;
    count(1024);
    chk("dens_beep_tape", 32'(ones_a), 240);
    chk("sat_beep_tape", 32'(ones_sat), 1023);
    tapeout = 1'b0;

    // 0xFF + beeper: 447 normal, saturated to 1023 with BEEP_LEVEL=1000.
    covox = 1'b1; d = 8'hFF;
    tick(3);
    covox = 1'b0;
    tick(2);
    chk("sat_smp", 32'(smp_sat), 32'hFF);
    count(1024);
    chk("dens_ff_beep", 32'(ones_a), 447);
    chk("sat_ff_beep", 32'(ones_sat), 1023);

    // Reset while strobe high and accumulator busy.
    covox = 1'b1; d = 8'h21;
    tick(5);
    #3 reset = 1'b0;
    #1;
    chk("rst_mid_pwm", 32'(pwm_a), 0);
    chk("rst_mid_smp", 32'(smp_a), 0);
    chk("rst_mid_pwm_sat", 32'(pwm_sat), 0);
    @(negedge cpu_clock);
    d = 8'h33; reset = 1'b1;
    tick(2);
    chk("rst_rel_wait", 32'(smp_a), 0);
    tick(1);
    chk("rst_rel_cap", 32'(smp_a), 32'h33);
    d = 8'h77;
    tick(5);
    chk("rst_rel_once", 32'(smp_a), 32'h33);
    covox = 1'b0; beeper = 1'b0;
    tick(3);

    // Idle timeout of 100 cycles on dut_to.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    covox = 1'b1; d = 8'h80;
    tick(3);
    chk("to_cap", 32'(smp_to), 32'h80);
    covox = 1'b0;
    tick(102);
    chk("to_cycle99", 32'(smp_to), 32'h80);
    tick(1);
    chk("to_cycle100", 32'(smp_to), 0);
    chk("no_to_default", 32'(smp_a), 32'h80);

    // A write landing on the 100th idle cycle wins over the timeout.
    covox = 1'b1; d = 8'h80;
    tick(3);
    covox = 1'b0;
    tick(100);
    covox = 1'b1; d = 8'h5A;
    tick(2);
    chk("to_race_pre", 32'(smp_to), 32'h80);
    tick(1);
    chk("to_race_win", 32'(smp_to), 32'h5A);
    covox = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
